// File: rtl/twiddle_stage_gen_pkg.sv
// Shared NTT stage definitions: default widths, modulus, lane bundle type and mode encoding.
package twiddle_stage_gen_pkg;
    localparam int NTT_DATA_WIDTH = 32;
    localparam int NTT_LANES      = 8;
    localparam int NTT_Q          = 12289;

    typedef logic [NTT_LANES-1:0][NTT_DATA_WIDTH-1:0] ntt_lanes_t;

    typedef enum logic {
        MODE_FWD = 1'b0,
        MODE_INV = 1'b1
    } ntt_mode_e;
endpackage

// File: rtl/twiddle_stage_gen_if.sv
// Streaming bus of the twiddle stage: input beat handshake plus output beat with frame marker.
interface twiddle_stage_gen_if
    import twiddle_stage_gen_pkg::*;
#(
    parameter int DATA_WIDTH = NTT_DATA_WIDTH,
    parameter int LANES      = NTT_LANES
);
    logic                             s_valid;
    logic                             s_ready;
    logic [LANES-1:0][DATA_WIDTH-1:0] s_data;
    logic                             m_valid;
    logic                             m_ready;
    logic [LANES-1:0][DATA_WIDTH-1:0] m_data;
    logic                             m_last;

    modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data, m_last);
    modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/twiddle_stage_gen_mod_mul_pipe.sv
// Pipelined (a*b) mod Q with stall enable; the reduction lands in stage 1, later stages only delay.
module mod_mul_pipe
    import twiddle_stage_gen_pkg::*;
#(
    parameter int DATA_WIDTH = NTT_DATA_WIDTH,
    parameter int Q          = NTT_Q,
    parameter int MUL_LAT    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  vld_i,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] p,
    output logic                  vld_o
);
    localparam int              PW = 2 * DATA_WIDTH;
    localparam logic [PW-1:0]   QP = PW'(Q);

    logic [PW-1:0]                     prod;
    logic [DATA_WIDTH-1:0]             red;
    logic [MUL_LAT:1]                  vld_pipe;
    logic [MUL_LAT:1][DATA_WIDTH-1:0]  d_pipe;

    assign prod = PW'(a) * PW'(b);
    assign red  = DATA_WIDTH'(prod % QP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else if (en) begin
            vld_pipe[1] <= vld_i;
            for (int i = 2; i <= MUL_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            d_pipe[1] <= red;
            for (int i = 2; i <= MUL_LAT; i++) d_pipe[i] <= d_pipe[i-1];
        end
    end

    assign p     = d_pipe[MUL_LAT];
    assign vld_o = vld_pipe[MUL_LAT];
endmodule

// File: rtl/twiddle_stage_gen.sv
// NTT twiddle stage: multiplies lanes 1..LANES-1 by a per-lane running power of a step root,
// restarting at 1 each frame; lane 0 and the frame-end flag ride the same pipeline.
module twiddle_stage_gen
    import twiddle_stage_gen_pkg::*;
#(
    parameter int DATA_WIDTH = NTT_DATA_WIDTH,
    parameter int LANES      = NTT_LANES,
    parameter int FRAME_LEN  = 1024,
    parameter int Q          = NTT_Q,
    parameter int MUL_LAT    = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             mode_inv,
    input  logic [LANES-1:0][DATA_WIDTH-1:0] step_fwd,
    input  logic [LANES-1:0][DATA_WIDTH-1:0] step_inv,
    twiddle_stage_gen_if.slave               bus,
    output logic [$clog2(FRAME_LEN)-1:0]     beat_idx
);
    localparam int                 IDX_W    = $clog2(FRAME_LEN);
    localparam int                 PW       = 2 * DATA_WIDTH;
    localparam logic [PW-1:0]      QP       = PW'(Q);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic                               en, acc, frame_end;
    ntt_mode_e                          mode_q, mode_eff;
    logic [LANES-1:1][DATA_WIDTH-1:0]   tw, tw_nxt, a_q, b_q, mul_p;
    logic [LANES-1:1]                   mul_vld;
    logic                               vld_s0;
    logic [MUL_LAT:0]                   last_pipe;
    logic [MUL_LAT:0][DATA_WIDTH-1:0]   lane0_pipe;
    logic                               unused_step0;

    // Lane 0 is never multiplied, so its step roots are intentionally ignored.
    assign unused_step0 = ^{step_fwd[0], step_inv[0]};

    assign en          = bus.m_ready || !bus.m_valid;
    assign bus.s_ready = en;
    assign acc         = bus.s_valid && en;
    assign frame_end   = (beat_idx == LAST_IDX);
    assign mode_eff    = (beat_idx == '0) ? ntt_mode_e'(mode_inv) : mode_q;

    for (genvar j = 1; j < LANES; j++) begin : g_tw
        logic [DATA_WIDTH-1:0] step;
        logic [PW-1:0]         tw_prod;
        assign step      = (mode_eff == MODE_INV) ? step_inv[j] : step_fwd[j];
        assign tw_prod   = PW'(tw[j]) * PW'(step);
        assign tw_nxt[j] = DATA_WIDTH'(tw_prod % QP);
    end

    // beat_idx wraps naturally because FRAME_LEN is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_idx <= '0;
            mode_q   <= MODE_FWD;
            for (int j = 1; j < LANES; j++) tw[j] <= DATA_WIDTH'(1);
        end else if (acc) begin
            beat_idx <= beat_idx + IDX_W'(1);
            if (beat_idx == '0) mode_q <= mode_eff;
            for (int j = 1; j < LANES; j++) tw[j] <= frame_end ? DATA_WIDTH'(1) : tw_nxt[j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_s0    <= 1'b0;
            last_pipe <= '0;
        end else if (en) begin
            vld_s0       <= bus.s_valid;
            last_pipe[0] <= bus.s_valid && frame_end;
            for (int i = 1; i <= MUL_LAT; i++) last_pipe[i] <= last_pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            a_q           <= bus.s_data[LANES-1:1];
            b_q           <= tw;
            lane0_pipe[0] <= bus.s_data[0];
            for (int i = 1; i <= MUL_LAT; i++) lane0_pipe[i] <= lane0_pipe[i-1];
        end
    end

    mod_mul_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .Q          (Q),
        .MUL_LAT    (MUL_LAT)
    ) u_mul [LANES-1:1] (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .vld_i (vld_s0),
        .a     (a_q),
        .b     (b_q),
        .p     (mul_p),
        .vld_o (mul_vld)
    );

    assign bus.m_valid = &mul_vld;
    assign bus.m_data  = {mul_p, lane0_pipe[MUL_LAT]};
    assign bus.m_last  = last_pipe[MUL_LAT];
endmodule

// File: tb/tb_twiddle_stage_gen.sv
// Bench for twiddle_stage_gen: table vectors, power-based golden model, backpressure, mid-frame reset.
module tb_twiddle_stage_gen;
    localparam int DW = 32;
    localparam int LN = 4;
    localparam int FL = 4;
    localparam int QM = 17;
    localparam int ML = 3;

    typedef struct {
        bit mode;
        int d[LN];
        int e[LN];
        bit last;
    } vec_t;

    typedef struct {
        logic [LN-1:0][DW-1:0] data;
        bit                    last;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  mode_inv = 1'b0;
    logic [LN-1:0][DW-1:0] step_fwd, step_inv;
    logic [1:0]            beat_idx;

    twiddle_stage_gen_if #(.DATA_WIDTH(DW), .LANES(LN)) bus ();

    twiddle_stage_gen #(
        .DATA_WIDTH (DW),
        .LANES      (LN),
        .FRAME_LEN  (FL),
        .Q          (QM),
        .MUL_LAT    (ML)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode_inv (mode_inv),
        .step_fwd (step_fwd),
        .step_inv (step_inv),
        .bus      (bus),
        .beat_idx (beat_idx)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   exp_idx = 0;
    int   first_out_cyc = -1;
    int   acc_cyc = 0;
    bit   bp_on = 1'b0;
    bit   mdl_mode = 1'b0;
    int   sf[LN] = '{1, 2, 4, 8};
    int   si[LN] = '{1, 9, 13, 15};
    exp_t sb[$];
    vec_t tbl[12];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Independent model: d * step^k mod Q, rather than a running product.
    function automatic int pmod(input int d, input int s, input int k);
        longint t = 1;
        for (int i = 0; i < k; i++) t = (t * s) % QM;
        return int'((longint'(d) * t) % QM);
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.m_valid && bus.m_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got extra output, want none (t=%0t)", $time);
            end else begin
                exp_t x;
                x = sb.pop_front();
                if (first_out_cyc < 0) first_out_cyc = cyc;
                for (int j = 0; j < LN; j++)
                    check($sformatf("lane%0d", j), longint'(bus.m_data[j]), longint'(x.data[j]));
                check("m_last", longint'(bus.m_last), longint'(x.last));
            end
        end
    end

    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = bp_on ? ($urandom_range(0, 99) < 60) : 1'b1;
        end
    end

    task automatic finish_now();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "bench aborted");
    endtask

    task automatic send(input bit mode, input logic [LN-1:0][DW-1:0] d, input exp_t e);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        mode_inv    = mode;
        @(negedge clk);
        while (!bus.s_ready) begin
            n++;
            if (n > 200) begin
                errors++;
                checks++;
                $display("FAIL s_ready_timeout: got no accept, want accept within 200 cycles");
                finish_now();
            end
            @(negedge clk);
        end
        @(posedge clk);
        sb.push_back(e);
        #1;
        acc_cyc     = cyc;
        bus.s_valid = 1'b0;
        exp_idx     = (exp_idx + 1) % FL;
        check("beat_idx", longint'(beat_idx), longint'(exp_idx));
    endtask

    task automatic send_model(input bit mode, input logic [LN-1:0][DW-1:0] d);
        exp_t e;
        if (exp_idx == 0) mdl_mode = mode;
        for (int j = 0; j < LN; j++)
            e.data[j] = (j == 0) ? d[j] : DW'(pmod(int'(d[j]), mdl_mode ? si[j] : sf[j], exp_idx));
        e.last = (exp_idx == FL - 1);
        send(mode, d, e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        idle(2);
        check("drain_empty", longint'(sb.size()), 0);
    endtask

    initial begin
        logic [LN-1:0][DW-1:0] d;
        exp_t                  e;
        int                    acc0;

        for (int j = 0; j < LN; j++) begin
            step_fwd[j] = DW'(sf[j]);
            step_inv[j] = DW'(si[j]);
        end
        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        tbl[0]  = '{0, '{1, 1, 1, 1},   '{1, 1, 1, 1},   0};
        tbl[1]  = '{0, '{1, 1, 1, 1},   '{1, 2, 4, 8},   0};
        tbl[2]  = '{0, '{1, 1, 1, 1},   '{1, 4, 16, 13}, 0};
        tbl[3]  = '{0, '{1, 1, 1, 1},   '{1, 8, 13, 2},  1};
        tbl[4]  = '{1, '{1, 1, 1, 1},   '{1, 1, 1, 1},   0};
        tbl[5]  = '{1, '{1, 1, 1, 1},   '{1, 9, 13, 15}, 0};
        tbl[6]  = '{0, '{1, 1, 1, 1},   '{1, 13, 16, 4}, 0};
        tbl[7]  = '{0, '{1, 1, 1, 1},   '{1, 15, 4, 9},  1};
        tbl[8]  = '{0, '{3, 5, 7, 11},  '{3, 5, 7, 11},  0};
        tbl[9]  = '{1, '{5, 16, 16, 16}, '{5, 15, 13, 9}, 0};
        tbl[10] = '{0, '{2, 3, 4, 5},   '{2, 12, 13, 14}, 0};
        tbl[11] = '{1, '{0, 16, 0, 1},  '{0, 9, 0, 2},   1};

        #12;
        check("rst_m_valid", longint'(bus.m_valid), 0);
        check("rst_m_last", longint'(bus.m_last), 0);
        check("rst_beat_idx", longint'(beat_idx), 0);
        check("rst_s_ready", longint'(bus.s_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < LN; j++) begin
                d[j]      = DW'(tbl[i].d[j]);
                e.data[j] = DW'(tbl[i].e[j]);
            end
            e.last = tbl[i].last;
            send(tbl[i].mode, d, e);
            if (i == 0) acc0 = acc_cyc;
        end
        drain();
        // Output cycle t+MUL_LAT+1 begins MUL_LAT edges after the accepting edge.
        check("latency", longint'(first_out_cyc - acc0), ML);

        bp_on = 1'b1;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < LN; j++) d[j] = DW'($urandom_range(0, QM - 1));
            send_model(1'($urandom_range(0, 1)), d);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();
        bp_on = 1'b0;
        idle(2);

        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < LN; j++) d[j] = DW'($urandom_range(0, QM - 1));
            send_model(1'b0, d);
        end
        @(posedge clk);
        #3;
        check("pre_reset_m_valid", longint'(bus.m_valid), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", longint'(bus.m_valid), 0);
        check("midrst_m_last", longint'(bus.m_last), 0);
        check("midrst_beat_idx", longint'(beat_idx), 0);
        sb.delete();
        exp_idx = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        d = {DW'(6), DW'(5), DW'(3), DW'(7)};
        send_model(1'b1, d);
        d = {DW'(2), DW'(11), DW'(4), DW'(9)};
        send_model(1'b0, d);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/twiddle_stage_gen.md
TWIDDLE_STAGE_GEN -- requirements
Module: twiddle_stage_gen

Interface
REQ-001 Parameter DATA_WIDTH, 32, coefficient width in bits.
REQ-002 Parameter LANES, 8, lanes per beat (>=2); lane 0 is never multiplied.
REQ-003 Parameter FRAME_LEN, 1024, beats per frame (power of two, >=2).
REQ-004 Parameter Q, 12289, modulus (Q < 2^DATA_WIDTH).
REQ-005 Parameter MUL_LAT, 3, pipeline stages of the data-path modular multiplier (>=1).
REQ-006 clk  in  1  clock; all state is updated on the rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 mode_inv  in  1  1 = inverse-NTT step roots, 0 = forward; sampled per frame.
REQ-009 step_fwd  in  LANES x DATA_WIDTH  per-lane forward step root, static during operation.
REQ-010 step_inv  in  LANES x DATA_WIDTH  per-lane inverse step root, static during operation.
REQ-011 s_valid / s_ready  in / out  1 / 1  input handshake.
REQ-012 s_data  in  LANES x DATA_WIDTH  input lanes, each value < Q.
REQ-013 m_valid / m_ready  out / in  1 / 1  output handshake.
REQ-014 m_data  out  LANES x DATA_WIDTH  output lanes.
REQ-015 m_last  out  1  marks the output beat at frame index FRAME_LEN-1.
REQ-016 beat_idx  out  log2(FRAME_LEN)  index of the next beat to be accepted.

Function
REQ-017 A beat is accepted when s_valid && s_ready, and delivered when m_valid && m_ready.
REQ-018 Pipeline enable: en = m_ready || !m_valid. s_ready = en. All pipeline stages hold while en is 0.
REQ-019 Latency: a beat accepted in cycle t appears at m_data in cycle t+MUL_LAT+1 when never stalled. Throughput: 1 beat/cycle.
REQ-020 Lane 0 output equals lane 0 input, delayed through the same pipeline.
REQ-021 Lane j>=1 output at frame index k SHALL be (s_data[j] * tw_j(k)) mod Q, with tw_j(0) = 1.
REQ-022 Twiddle recurrence on each accepted beat: tw_j(k+1) = (tw_j(k) * step_j) mod Q, computed in one cycle with a 2*DATA_WIDTH-bit product.
REQ-023 Step-root selection: step_j = step_inv[j] if mode_eff else step_fwd[j]; mode_eff = mode_inv when beat_idx==0, otherwise the latched mode.
REQ-024 mode_inv is latched on acceptance of the beat at index 0. Changes of mode_inv mid-frame have no effect until the next frame.
REQ-025 beat_idx increments on each accepted beat. After the beat at FRAME_LEN-1 it wraps to 0 and all tw_j reload to 1 in the same edge.
REQ-026 m_last travels with the beat through the pipeline and is asserted exactly for the frame-index-FRAME_LEN-1 beat.
REQ-027 If s_valid is low, no state advances except pipeline drain. Bubbles propagate with valid=0.
REQ-028 If an accept and an output stall occur in the same cycle, s_ready is already 0, so no beat is lost or duplicated.
REQ-029 Data-path products are 2*DATA_WIDTH bits wide. Every output is reduced to the range [0, Q).

Reset
REQ-030 On rst_n low, asynchronously: m_valid=0, m_last=0, beat_idx=0, latched mode=0, all tw_j=1, and all pipeline valid bits cleared.
REQ-031 m_data and pipeline data registers need not reset. Their value is don't-care while m_valid=0.
REQ-032 A reset asserted mid-frame abandons that frame. The first beat accepted after release is frame index 0.

Structure
REQ-033 DATA_WIDTH, LANES, Q defaults and the lane array typedef live in the shared NTT defines package, reused by the neighbouring stages.
REQ-034 Sub-module mod_mul_pipe holds the MUL_LAT-stage (a*b) mod Q multiplier with enable and a valid sideband. One instance is used per lane j>=1.
REQ-035 The twiddle recurrence multiplier is combinational, inside twiddle_stage_gen.

Verification (Q=17, LANES=4, FRAME_LEN=4, MUL_LAT=3, step_fwd={1,2,4,8}, step_inv={1,9,13,15})
REQ-036 Forward, s_data all 1, no stalls: output beats are [1,1,1,1], [1,2,4,8], [1,4,16,13], [1,8,13,2]. The first output appears 4 cycles after accept, and m_last is set on beat 3.
REQ-037 mode_inv=1, s_data all 1: beat 1 is [1,9,13,15]. Toggling mode_inv at beat 2 leaves beat 2 at [1,13,16,4].
REQ-038 Back-to-back frames: beat 4 restarts at tw=1, giving [1,1,1,1] with beat_idx=0. Random m_ready backpressure keeps the output equal to the golden model with no loss or duplication.
REQ-039 s_data lanes = [5,16,16,16] at index 1, forward: output [5,15,13,9].
REQ-040 Assert rst_n at beat 2 of a frame: m_valid drops immediately. The next accepted beat produces [x,1·d1,1·d2,1·d3], i.e. tw=1.
